rr_stream_mux: RTL and testbench

- Parametrised N-channel, K-bit stream multiplexer with a registered output and a valid/ready handshake on every input and on the output.
- Two selection modes: fixed binary select, or round-robin arbitration among requesting channels.
- Packet lock: a granted channel is held until it sends a beat with last=1.
- Sits between multiple producer streams and one consumer. Replaces the combinational 3-way select mux wherever backpressure or fairness is needed.

---
 rtl/rr_stream_mux.sv | 118 +++++++++++
 tb/tb_rr_stream_mux.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream multiplexer with a registered output stage.
// Channels are picked by a fixed select or round-robin and stay locked until the last beat of a packet.
module rr_stream_mux #(
    parameter  int K  = 8,
    parameter  int N  = 3,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    input  logic [N*K-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    input  logic [N-1:0]   in_last,
    output logic [N-1:0]   in_ready,
    output logic [K-1:0]   out_data,
    output logic           out_valid,
    output logic           out_last,
    input  logic           out_ready,
    output logic [SW-1:0]  grant,
    output logic           busy
);

    logic [K-1:0]  r_out_data;
    logic          r_out_valid;
    logic          r_out_last;
    logic [SW-1:0] r_grant;
    logic          r_busy;
    logic [SW-1:0] r_ptr;

    logic          w_free;
    logic          w_cand_vld;
    logic [SW-1:0] w_cand;
    logic [SW-1:0] w_rr_cand;
    logic          w_rr_vld;
    logic [N-1:0]  w_ready;
    logic          w_in_xfer;
    logic [K-1:0]  w_sel_data;
    logic          w_sel_last;

    assign w_free = !r_out_valid || out_ready;

    // Scan ptr+1, ptr+2, ... so the most recently served channel has lowest priority.
    always_comb begin
        w_rr_vld  = 1'b0;
        w_rr_cand = '0;
        for (int i = 1; i <= N; i++) begin
            int idx;
            idx = (int'(r_ptr) + i) % N;
            if (!w_rr_vld && in_valid[idx]) begin
                w_rr_vld  = 1'b1;
                w_rr_cand = SW'(idx);
            end
        end
    end

    always_comb begin
        w_cand_vld = 1'b0;
        w_cand     = '0;
        if (r_busy) begin
            w_cand_vld = 1'b1;
            w_cand     = r_grant;
        end else if (!mode) begin
            w_cand_vld = (int'(sel) < N);
            w_cand     = sel;
        end else begin
            w_cand_vld = w_rr_vld;
            w_cand     = w_rr_cand;
        end
    end

    always_comb begin
        w_ready    = '0;
        w_sel_data = '0;
        w_sel_last = 1'b0;
        for (int c = 0; c < N; c++) begin
            if (w_cand == SW'(c)) begin
                w_ready[c] = rst_n && w_free && w_cand_vld;
                w_sel_data = in_data[c*K +: K];
                w_sel_last = in_last[c];
            end
        end
    end

    assign in_ready  = w_ready;
    assign w_in_xfer = |(in_valid & w_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_grant     <= '0;
            r_busy      <= 1'b0;
            r_ptr       <= SW'(N - 1);
        end else begin
            if (w_in_xfer) begin
                r_out_data  <= w_sel_data;
                r_out_last  <= w_sel_last;
                r_out_valid <= 1'b1;
                r_grant     <= w_cand;
                r_busy      <= !w_sel_last;
                // Pointer moves once per packet, at its final beat.
                if (mode && w_sel_last)
                    r_ptr <= w_cand;
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign grant     = r_grant;
    assign busy      = r_busy;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Directed testbench for rr_stream_mux (N=3, K=8).
// Inputs change 1 ns after the rising edge; outputs are checked before the next edge.
module tb_rr_stream_mux;

    localparam int K  = 8;
    localparam int N  = 3;
    localparam int SW = $clog2(N);

    logic           clk = 1'b0;
    logic           rst_n;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [N-1:0][K-1:0] d;
    logic [N*K-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;
    logic [K-1:0]   out_data;
    logic           out_valid;
    logic           out_last;
    logic           out_ready;
    logic [SW-1:0]  grant;
    logic           busy;

    int checks   = 0;
    int failures = 0;

    assign in_data = d;

    always #5 clk = ~clk;

    rr_stream_mux #(.K(K), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .grant     (grant),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [N-1:0] exp_rdy;
        int           g;

        rst_n     = 1'b0;
        mode      = 1'b1;
        sel       = '0;
        d[0]      = 8'h10;
        d[1]      = 8'h20;
        d[2]      = 8'h30;
        in_valid  = 3'b111;
        in_last   = 3'b111;
        out_ready = 1'b1;

        // 1. reset with all inputs valid
        step();
        step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_grant",     32'(grant),     32'd0);
        check("rst_busy",      32'(busy),      32'd0);
        check("rst_in_ready",  32'(in_ready),  32'b000);
        check("rst_out_data",  32'(out_data),  32'h00);

        rst_n = 1'b1;
        #1;
        check("rr_first_ch0", 32'(in_ready), 32'b001);

        // 4. round-robin fairness, one beat per cycle
        for (int k = 0; k < 6; k++) begin
            g       = k % 3;
            exp_rdy = 3'b001 << g;
            check($sformatf("rr_ready_%0d", k), 32'(in_ready), 32'(exp_rdy));
            step();
            check($sformatf("rr_grant_%0d", k), 32'(grant),     32'(g));
            check($sformatf("rr_valid_%0d", k), 32'(out_valid), 32'd1);
            check($sformatf("rr_data_%0d", k),  32'(out_data),  32'(8'h10 * (g + 1)));
        end
        in_valid = 3'b000;
        step();
        check("drain_valid", 32'(out_valid), 32'd0);
        check("drain_grant", 32'(grant),     32'd2);

        // 2. fixed select of channel 2
        mode     = 1'b0;
        sel      = 2'd2;
        d[2]     = 8'hA5;
        in_valid = 3'b111;
        #1;
        check("fix_ready", 32'(in_ready), 32'b100);
        step();
        check("fix_valid", 32'(out_valid), 32'd1);
        check("fix_data",  32'(out_data),  32'hA5);
        check("fix_last",  32'(out_last),  32'd1);
        check("fix_grant", 32'(grant),     32'd2);

        // 3. out-of-range select: nothing granted, output drains
        sel = 2'd3;
        #1;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bad_sel_ready_%0d", k), 32'(in_ready), 32'b000);
            step();
            check($sformatf("bad_sel_valid_%0d", k), 32'(out_valid), 32'd0);
        end

        // 5. packet lock; pointer currently at 2, single ch0 beat moves it to 0
        mode     = 1'b1;
        sel      = 2'd0;
        in_valid = 3'b011;
        in_last  = 3'b001;
        d[0]     = 8'h0A;
        d[1]     = 8'h11;
        #1;
        check("pk_pre_ready", 32'(in_ready), 32'b001);
        step();
        check("pk_pre_data", 32'(out_data), 32'h0A);
        check("pk_pre_busy", 32'(busy),     32'd0);
        check("pk_b1_ready", 32'(in_ready), 32'b010);
        step();
        check("pk_b1_data", 32'(out_data), 32'h11);
        check("pk_b1_last", 32'(out_last), 32'd0);
        check("pk_b1_busy", 32'(busy),     32'd1);
        d[1] = 8'h22;
        mode = 1'b0;
        sel  = 2'd0;
        #1;
        check("pk_b2_ready_locked", 32'(in_ready), 32'b010);
        step();
        check("pk_b2_data",  32'(out_data), 32'h22);
        check("pk_b2_busy",  32'(busy),     32'd1);
        check("pk_b2_grant", 32'(grant),    32'd1);
        mode    = 1'b1;
        d[1]    = 8'h33;
        in_last = 3'b011;
        #1;
        check("pk_b3_ready", 32'(in_ready), 32'b010);
        step();
        check("pk_b3_data", 32'(out_data), 32'h33);
        check("pk_b3_last", 32'(out_last), 32'd1);
        check("pk_b3_busy", 32'(busy),     32'd0);
        in_valid = 3'b001;
        #1;
        check("pk_after_ready", 32'(in_ready), 32'b001);
        step();
        check("pk_after_grant", 32'(grant),    32'd0);
        check("pk_after_data",  32'(out_data), 32'h0A);

        // 6. backpressure during a locked packet, then async reset
        in_valid = 3'b100;
        in_last  = 3'b000;
        d[2]     = 8'h5C;
        #1;
        check("bp_start_ready", 32'(in_ready), 32'b100);
        step();
        check("bp_start_busy", 32'(busy),     32'd1);
        check("bp_start_data", 32'(out_data), 32'h5C);
        out_ready = 1'b0;
        in_valid  = 3'b111;
        d[2]      = 8'h77;
        #1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("bp_ready_%0d", k), 32'(in_ready), 32'b000);
            step();
            check($sformatf("bp_data_%0d", k),  32'(out_data),  32'h5C);
            check($sformatf("bp_valid_%0d", k), 32'(out_valid), 32'd1);
            check($sformatf("bp_grant_%0d", k), 32'(grant),     32'd2);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_busy",  32'(busy),      32'd0);
        check("arst_ready", 32'(in_ready),  32'b000);
        check("arst_data",  32'(out_data),  32'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
